// File: rtl/ms_pkg.sv
// Shared minesweeper grid geometry, flood-fill FSM states and tile coordinate helpers.
package ms_pkg;

    localparam int COLS  = 8;
    localparam int ROWS  = 8;
    localparam int TILES = ROWS * COLS;
    localparam int IDX_W = $clog2(TILES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        POP   = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } fill_state_t;

    function automatic int row_of(input int idx);
        return idx / COLS;
    endfunction

    function automatic int col_of(input int idx);
        return idx % COLS;
    endfunction

endpackage

// File: rtl/tile_neighbors.sv
// Combinational neighbour mask and adjacent-mine count for one tile (no wrap at grid edges).
module tile_neighbors
    import ms_pkg::*;
(
    input  logic [IDX_W-1:0] index,
    input  logic [TILES-1:0] mine_map,
    output logic [TILES-1:0] nbr_mask,
    output logic [3:0]       adj_count
);

    int row;
    int col;
    int dr;
    int dc;

    // A tile is a neighbour when its row and column each differ by at most one, excluding itself.
    always_comb begin
        nbr_mask  = '0;
        adj_count = '0;
        row       = row_of(int'(index));
        col       = col_of(int'(index));
        dr        = 0;
        dc        = 0;
        for (int i = 0; i < TILES; i++) begin
            dr = row_of(i) - row;
            dc = col_of(i) - col;
            nbr_mask[i] = (dr >= -1) && (dr <= 1) && (dc >= -1) && (dc <= 1)
                          && !((dr == 0) && (dc == 0));
        end
        for (int i = 0; i < TILES; i++) begin
            adj_count = adj_count + 4'(nbr_mask[i] & mine_map[i]);
        end
    end

endmodule

// File: rtl/flood_reveal.sv
// Minesweeper flood-fill: turns one reveal request into a stream of one-tile reveal strobes.
module flood_reveal
    import ms_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IDX_W-1:0] start_index,
    input  logic [TILES-1:0] mine_map,
    input  logic [TILES-1:0] flagged,
    input  logic [TILES-1:0] revealed,
    output logic [IDX_W-1:0] tile_index,
    output logic             reveal,
    output logic             busy,
    output logic             done,
    output logic             hit_mine,
    output logic [IDX_W:0]   reveal_count
);

    localparam logic [TILES-1:0] ONE = TILES'(1);

    fill_state_t      state;
    logic [TILES-1:0] pending;
    logic [TILES-1:0] visited;
    logic [IDX_W-1:0] pick;
    logic [TILES-1:0] nbr_mask;
    logic [3:0]       adj_count;

    tile_neighbors u_nbr (
        .index     (tile_index),
        .mine_map  (mine_map),
        .nbr_mask  (nbr_mask),
        .adj_count (adj_count)
    );

    // Lowest set bit of the work list wins.
    always_comb begin
        pick = '0;
        for (int i = TILES - 1; i >= 0; i--) begin
            if (pending[i]) begin
                pick = IDX_W'(i);
            end
        end
    end

    assign reveal = (state == ISSUE);
    assign busy   = (state == POP) || (state == ISSUE);
    assign done   = (state == DONE);

    // visited is needed alongside revealed because the tile register only
    // reflects a strobe one cycle later. DONE accepts a new start like IDLE
    // since busy is already low there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            pending      <= '0;
            visited      <= '0;
            tile_index   <= '0;
            hit_mine     <= 1'b0;
            reveal_count <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (start) begin
                        visited      <= '0;
                        hit_mine     <= 1'b0;
                        reveal_count <= '0;
                        if (flagged[start_index] || revealed[start_index]) begin
                            state <= DONE;
                        end else if (mine_map[start_index]) begin
                            tile_index <= start_index;
                            hit_mine   <= 1'b1;
                            pending    <= '0;
                            state      <= ISSUE;
                        end else begin
                            pending <= ONE << start_index;
                            state   <= POP;
                        end
                    end
                end
                POP: begin
                    if (pending == '0) begin
                        state <= DONE;
                    end else begin
                        pending    <= pending & ~(ONE << pick);
                        visited    <= visited | (ONE << pick);
                        tile_index <= pick;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    reveal_count <= reveal_count + (IDX_W+1)'(1);
                    if ((adj_count == 4'd0) && !mine_map[tile_index]) begin
                        pending <= pending | (nbr_mask & ~mine_map & ~flagged & ~revealed & ~visited);
                    end
                    state <= POP;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flood_reveal.sv
// Randomised and directed bench for flood_reveal against a queue-based flood-fill model.
module tb_flood_reveal;

    logic        clk;
    logic        rst;
    logic        start;
    logic [5:0]  start_index;
    logic [63:0] mine_map;
    logic [63:0] flagged;
    logic [63:0] revealed;
    logic [5:0]  tile_index;
    logic        reveal;
    logic        busy;
    logic        done;
    logic        hit_mine;
    logic [6:0]  reveal_count;

    int vectors;
    int miscompares;

    int seen_cnt [64];
    int n_strobe;
    int first_t;
    int last_t;
    int done_t;
    int done_cnt;
    int first_tile;
    int extra;
    int busy_at_1;
    bit timed_out;

    flood_reveal dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .start_index  (start_index),
        .mine_map     (mine_map),
        .flagged      (flagged),
        .revealed     (revealed),
        .tile_index   (tile_index),
        .reveal       (reveal),
        .busy         (busy),
        .done         (done),
        .hit_mine     (hit_mine),
        .reveal_count (reveal_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mines among the up-to-8 surrounding tiles of tile i on an 8x8 board.
    function automatic int adj_mines(input logic [63:0] m, input int i);
        int n;
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if (!(dr == 0 && dc == 0) && (i / 8 + dr >= 0) && (i / 8 + dr < 8)
                    && (i % 8 + dc >= 0) && (i % 8 + dc < 8)) begin
                    if (m[(i / 8 + dr) * 8 + (i % 8 + dc)]) n++;
                end
            end
        end
        return n;
    endfunction

    // Classic breadth-first flood fill: the set of tiles a request should reveal.
    function automatic logic [63:0] model_fill(input logic [63:0] m, input logic [63:0] f,
                                               input logic [63:0] r, input int s);
        logic [63:0] res;
        int q[$];
        int cur;
        int nb;
        res = '0;
        if (f[s] || r[s]) return res;
        res[s] = 1'b1;
        if (m[s]) return res;
        q.push_back(s);
        while (q.size() > 0) begin
            cur = q.pop_front();
            if (adj_mines(m, cur) == 0) begin
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (!(dr == 0 && dc == 0) && (cur / 8 + dr >= 0) && (cur / 8 + dr < 8)
                            && (cur % 8 + dc >= 0) && (cur % 8 + dc < 8)) begin
                            nb = (cur / 8 + dr) * 8 + (cur % 8 + dc);
                            if (!m[nb] && !f[nb] && !r[nb] && !res[nb]) begin
                                res[nb] = 1'b1;
                                q.push_back(nb);
                            end
                        end
                    end
                end
            end
        end
        return res;
    endfunction

    // Issue one request and record every strobe; t counts cycles after the start edge.
    task automatic applyRequest(input int idx, input bit track, input int poke_t, input int poke_idx);
        int t;
        for (int i = 0; i < 64; i++) seen_cnt[i] = 0;
        n_strobe = 0; first_t = -1; last_t = -1; done_t = -1; done_cnt = 0;
        first_tile = -1; extra = 0; busy_at_1 = 0; timed_out = 1'b0;
        @(negedge clk);
        start = 1'b1;
        start_index = 6'(idx);
        @(posedge clk);
        #1 start = 1'b0;
        t = 0;
        while (done_cnt == 0 && !timed_out) begin
            @(negedge clk);
            t++;
            if (t == 1) busy_at_1 = int'(busy);
            if (reveal) begin
                seen_cnt[tile_index]++;
                if (n_strobe == 0) begin
                    first_t = t;
                    first_tile = int'(tile_index);
                end
                last_t = t;
                n_strobe++;
                if (track && !flagged[tile_index]) revealed[tile_index] = 1'b1;
            end
            if (done) begin
                done_t = t;
                done_cnt++;
            end
            start = (poke_t > 0) && (t == poke_t);
            start_index = 6'(poke_idx);
            if (t > 400) timed_out = 1'b1;
        end
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (reveal || done) extra++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; start_index = '0;
        mine_map = '0; flagged = '0; revealed = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({reveal, busy, done, hit_mine} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_flags: got %b expected 0000", {reveal, busy, done, hit_mine});
        end
        vectors++;
        if ({tile_index, reveal_count} !== 13'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_regs: got idx %0d count %0d expected 0 0", tile_index, reveal_count);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        vectors++;
        if ({reveal, busy, done} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL reset_idle: got %b expected 000", {reveal, busy, done});
        end
    endtask

    task automatic test_open_board;
        mine_map = '0; flagged = '0; revealed = '0;
        applyRequest(0, 1'b0, 0, 0);
        vectors++;
        if (timed_out || n_strobe != 64) begin
            miscompares++;
            $display("[TB] FAIL open_strobes: got %0d expected 64 (timeout %0d)", n_strobe, timed_out);
        end
        vectors++;
        if (first_tile != 0 || first_t != 2) begin
            miscompares++;
            $display("[TB] FAIL open_first: got tile %0d at %0d expected tile 0 at 2", first_tile, first_t);
        end
        vectors++;
        if (busy_at_1 != 1) begin
            miscompares++;
            $display("[TB] FAIL open_busy: got %0d expected 1", busy_at_1);
        end
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 64; i++) if (seen_cnt[i] != 1) bad++;
            vectors++;
            if (bad != 0) begin
                miscompares++;
                $display("[TB] FAIL open_once: got %0d tiles not strobed exactly once expected 0", bad);
            end
        end
        vectors++;
        if (last_t - first_t != 126 || done_t != last_t + 2) begin
            miscompares++;
            $display("[TB] FAIL open_timing: got span %0d done %0d expected span 126 done %0d",
                     last_t - first_t, done_t, last_t + 2);
        end
        vectors++;
        if (reveal_count !== 7'd64 || hit_mine !== 1'b0 || done_cnt != 1 || extra != 0) begin
            miscompares++;
            $display("[TB] FAIL open_final: got count %0d hit %b dones %0d extra %0d expected 64 0 1 0",
                     reveal_count, hit_mine, done_cnt, extra);
        end
    endtask

    task automatic test_corner_mine;
        logic [63:0] exp_set;
        int bad;
        mine_map = 64'd1 << 63; flagged = '0; revealed = '0;
        exp_set = model_fill(mine_map, flagged, revealed, 0);
        applyRequest(0, 1'b0, 0, 0);
        bad = 0;
        for (int i = 0; i < 64; i++) if (seen_cnt[i] != int'(exp_set[i])) bad++;
        vectors++;
        if (timed_out || bad != 0 || seen_cnt[63] != 0 || seen_cnt[54] != 1) begin
            miscompares++;
            $display("[TB] FAIL corner_set: got %0d wrong tiles expected 0", bad);
        end
        vectors++;
        if (reveal_count !== 7'd63 || n_strobe != 63) begin
            miscompares++;
            $display("[TB] FAIL corner_count: got %0d/%0d expected 63", reveal_count, n_strobe);
        end
    endtask

    task automatic test_hit_mine;
        mine_map = 64'd1 << 27; flagged = '0; revealed = '0;
        applyRequest(27, 1'b0, 0, 0);
        vectors++;
        if (timed_out || n_strobe != 1 || first_tile != 27) begin
            miscompares++;
            $display("[TB] FAIL mine_strobe: got %0d strobes tile %0d expected 1 tile 27", n_strobe, first_tile);
        end
        vectors++;
        if (done_t != last_t + 2) begin
            miscompares++;
            $display("[TB] FAIL mine_done: got done at %0d expected %0d", done_t, last_t + 2);
        end
        vectors++;
        if (hit_mine !== 1'b1 || reveal_count !== 7'd1 || tile_index !== 6'd27) begin
            miscompares++;
            $display("[TB] FAIL mine_held: got hit %b count %0d idx %0d expected 1 1 27",
                     hit_mine, reveal_count, tile_index);
        end
    endtask

    task automatic test_flag_row;
        mine_map = '0; flagged = 64'hFF00; revealed = '0;
        applyRequest(0, 1'b0, 0, 0);
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 64; i++) if (seen_cnt[i] != ((i < 8) ? 1 : 0)) bad++;
            vectors++;
            if (timed_out || bad != 0 || reveal_count !== 7'd8) begin
                miscompares++;
                $display("[TB] FAIL flag_row: got %0d wrong tiles count %0d expected 0 8", bad, reveal_count);
            end
        end
        revealed = 64'd1 << 5;
        applyRequest(5, 1'b0, 0, 0);
        vectors++;
        if (n_strobe != 0 || done_t != 1 || reveal_count !== 7'd0) begin
            miscompares++;
            $display("[TB] FAIL revealed_start: got strobes %0d done %0d count %0d expected 0 1 0",
                     n_strobe, done_t, reveal_count);
        end
    endtask

    task automatic test_back_to_back;
        mine_map = '0; flagged = '0; revealed = '0;
        applyRequest(0, 1'b0, 5, 40);
        vectors++;
        if (timed_out || n_strobe != 64 || reveal_count !== 7'd64 || done_cnt != 1 || extra != 0) begin
            miscompares++;
            $display("[TB] FAIL busy_ignore: got strobes %0d count %0d extra %0d expected 64 64 0",
                     n_strobe, reveal_count, extra);
        end
    endtask

    task automatic test_random;
        logic [63:0] exp_set;
        int s;
        int bad;
        for (int it = 0; it < 24; it++) begin
            for (int i = 0; i < 64; i++) begin
                mine_map[i] = ($urandom_range(0, 9) == 0);
                flagged[i]  = ($urandom_range(0, 19) == 0);
            end
            revealed = '0;
            s = int'($urandom_range(0, 63));
            exp_set = model_fill(mine_map, flagged, revealed, s);
            applyRequest(s, 1'b1, 0, 0);
            bad = 0;
            for (int i = 0; i < 64; i++) if (seen_cnt[i] != int'(exp_set[i])) bad++;
            vectors++;
            if (timed_out || bad != 0) begin
                miscompares++;
                $display("[TB] FAIL rand_set[%0d]: got %0d wrong tiles expected 0", it, bad);
            end
            vectors++;
            if (reveal_count !== 7'($countones(exp_set))
                || hit_mine !== (mine_map[s] && !flagged[s])) begin
                miscompares++;
                $display("[TB] FAIL rand_count[%0d]: got count %0d hit %b expected %0d %b", it,
                         reveal_count, hit_mine, $countones(exp_set), mine_map[s] && !flagged[s]);
            end
            vectors++;
            if (done_cnt != 1 || done_t != ((n_strobe == 0) ? 1 : last_t + 2)) begin
                miscompares++;
                $display("[TB] FAIL rand_done[%0d]: got done at %0d expected %0d", it, done_t,
                         (n_strobe == 0) ? 1 : last_t + 2);
            end
        end
    endtask

    task automatic test_reset_midfill;
        int leaks;
        mine_map = '0; flagged = '0; revealed = '0;
        @(negedge clk);
        start = 1'b1;
        start_index = 6'd9;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({reveal, busy, done, hit_mine} !== 4'b0000 || tile_index !== 6'd0 || reveal_count !== 7'd0) begin
            miscompares++;
            $display("[TB] FAIL midfill_reset: got %b idx %0d count %0d expected 0000 0 0",
                     {reveal, busy, done, hit_mine}, tile_index, reveal_count);
        end
        @(negedge clk);
        rst = 1'b0;
        leaks = 0;
        repeat (20) begin
            @(negedge clk);
            if (reveal || busy || done) leaks++;
        end
        vectors++;
        if (leaks != 0) begin
            miscompares++;
            $display("[TB] FAIL midfill_release: got %0d active cycles expected 0", leaks);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_open_board();
        test_corner_mine();
        test_hit_mine();
        test_flag_row();
        test_back_to_back();
        test_random();
        test_reset_midfill();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
